// File: rtl/key_debouncer_pkg.sv
// debounce_pkg: shared debounce constants and input-normalisation helper
package debounce_pkg;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int SIM_DEBOUNCE_CYCLES = 4;
  localparam logic RELEASED = 1'b0;
  function automatic logic normalise(logic raw, bit active_low);
    return active_low ? ~raw : raw;
  endfunction
endpackage

// File: rtl/key_debouncer_if.sv
// key_debouncer_if: raw key pin in, debounced level and press/release events out
interface key_debouncer_if;
  logic button;
  logic key_press;
  logic key_release;
  logic key_state;
  modport master (output button, input key_press, key_release, key_state);
  modport slave (input button, output key_press, key_release, key_state);
endinterface

// File: rtl/key_debouncer_sync.sv
// sync_2ff: two-flop synchroniser with configurable reset level
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_mod,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge reset_mod)
    if (!reset_mod) {q, meta} <= {2{RESET_VAL}};
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/key_debouncer.sv
// key_debouncer: filters a bouncing key into a stable level plus one-cycle press/release pulses
module key_debouncer
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
  input logic clk,
  input logic reset_mod,
  key_debouncer_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic pressed_raw, sync2, stable;
  logic [CW-1:0] cnt;
  assign pressed_raw = normalise(bus.button, BUTTON_ACTIVE_LOW);
  sync_2ff #(.RESET_VAL(RELEASED)) u_sync (
    .clk(clk),
    .reset_mod(reset_mod),
    .d(pressed_raw),
    .q(sync2)
  );
  // any sample agreeing with the accepted level restarts the stability count
  always_ff @(posedge clk or negedge reset_mod)
    if (!reset_mod) begin
      stable <= RELEASED;
      cnt <= '0;
      bus.key_press <= 1'b0;
      bus.key_release <= 1'b0;
    end else begin
      bus.key_press <= 1'b0;
      bus.key_release <= 1'b0;
      if (sync2 == stable) cnt <= '0;
      else if (cnt == CNT_MAX) begin
        stable <= sync2;
        cnt <= '0;
        bus.key_press <= sync2;
        bus.key_release <= ~sync2;
      end else cnt <= cnt + CW'(1);
    end
  assign bus.key_state = stable;
endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: scoreboard of expected press/release events against two polarity variants
module tb_key_debouncer;
  import debounce_pkg::*;
  localparam int LAT = SIM_DEBOUNCE_CYCLES + 2;
  logic clk = 1'b0;
  logic reset_mod = 1'b0;
  int cyc = 0;
  int vectors = 0;
  int errors = 0;
  int exp_q[$];
  key_debouncer_if bif0 ();
  key_debouncer_if bif1 ();
  key_debouncer #(.DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES), .BUTTON_ACTIVE_LOW(1'b1)) u_dut_lo (
    .clk(clk), .reset_mod(reset_mod), .bus(bif0.slave)
  );
  key_debouncer #(.DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES), .BUTTON_ACTIVE_LOW(1'b0)) u_dut_hi (
    .clk(clk), .reset_mod(reset_mod), .bus(bif1.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string tag, int got, int exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  // event code: edge number, DUT index, release flag
  function automatic int ev(int c, int d, int rel);
    return c * 4 + d * 2 + rel;
  endfunction
  task automatic expect_ev(int d, int rel);
    exp_q.push_back(ev(cyc + LAT, d, rel));
  endtask
  task automatic wait_cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic observe(int d, logic p, logic r);
    if (p || r) begin
      chk($sformatf("overlap%0d", d), int'(p & r), 0);
      if (exp_q.size() == 0) chk($sformatf("unexpected%0d", d), ev(cyc, d, int'(r)), -1);
      else chk($sformatf("event%0d", d), ev(cyc, d, int'(r)), exp_q.pop_front());
    end
  endtask
  always @(negedge clk) begin
    observe(0, bif0.key_press, bif0.key_release);
    observe(1, bif1.key_press, bif1.key_release);
  end
  task automatic chk_outs(string tag, int d, logic st);
    if (d == 0) begin
      chk({tag, "_state"}, int'(bif0.key_state), int'(st));
      chk({tag, "_press"}, int'(bif0.key_press), 0);
      chk({tag, "_release"}, int'(bif0.key_release), 0);
    end else begin
      chk({tag, "_state"}, int'(bif1.key_state), int'(st));
      chk({tag, "_press"}, int'(bif1.key_press), 0);
      chk({tag, "_release"}, int'(bif1.key_release), 0);
    end
  endtask
  initial begin
    bif0.button = 1'b0;
    bif1.button = 1'b0;
    wait_cyc(4);
    chk_outs("reset_lo", 0, 1'b0);
    chk_outs("reset_hi", 1, 1'b0);
    reset_mod = 1'b1;
    expect_ev(0, 0);
    wait_cyc(10);
    chk("held_press_state", int'(bif0.key_state), 1);
    bif0.button = 1'b1;
    expect_ev(0, 1);
    wait_cyc(10);
    chk("release_state", int'(bif0.key_state), 0);
    bif0.button = 1'b0;
    expect_ev(0, 0);
    wait_cyc(10);
    chk("press_state", int'(bif0.key_state), 1);
    bif0.button = 1'b1;
    expect_ev(0, 1);
    wait_cyc(10);
    foreach (exp_q[i]) chk("stale_entry", exp_q[i], -1);
    for (int i = 0; i < 5; i++) begin
      bif0.button = i[0];
      if (i == 4) expect_ev(0, 0);
      wait_cyc(1);
    end
    wait_cyc(10);
    chk("bounce_state", int'(bif0.key_state), 1);
    bif0.button = 1'b1;
    expect_ev(0, 1);
    wait_cyc(10);
    bif0.button = 1'b0;
    wait_cyc(3);
    bif0.button = 1'b1;
    wait_cyc(10);
    chk_outs("glitch", 0, 1'b0);
    bif0.button = 1'b0;
    wait_cyc(4);
    reset_mod = 1'b0;
    wait_cyc(3);
    chk_outs("midcount_rst", 0, 1'b0);
    bif0.button = 1'b1;
    reset_mod = 1'b1;
    wait_cyc(10);
    chk_outs("after_rst", 0, 1'b0);
    bif1.button = 1'b1;
    expect_ev(1, 0);
    wait_cyc(10);
    chk("polarity_press", int'(bif1.key_state), 1);
    bif1.button = 1'b0;
    expect_ev(1, 1);
    wait_cyc(10);
    chk("polarity_release", int'(bif1.key_state), 0);
    chk("drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
